change_dispense_sequencer: RTL and testbench
============================================

// Module: change_dispense_sequencer
// PURPOSE
//  Pays out change owed after a vend by driving three coin hoppers ($5, $2, $1) one coin at a time.
//  Sits between the vend controller's change output and the hopper motor drivers.
//  Tracks the coin count in each hopper. Picks the largest coin that fits, then confirms each drop with the coin sensor.
//  Reports done and short-pay to the controller.
// PARAMETERS
//  PULSE_CYCLES  4   cycles the eject line is held high per coin
//  TIMEOUT       16  cycles to wait in WAIT_SENSE for coin_sensed before declaring a jam
//  GAP_CYCLES    2   idle cycles between coins
//  CNT_W         4   width of each hopper coin counter
// PORTS
//  clk           in   1      system clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      begin payout of change_amt (sampled in IDLE only)
//  change_amt    in   8      amount owed in dollars, unsigned
//  refill        in   1      load hopper counts from refill_cnt* (IDLE only)
//  refill_cnt5   in   CNT_W  new $5 count
//  refill_cnt2   in   CNT_W  new $2 count
//  refill_cnt1   in   CNT_W  new $1 count
//  coin_sensed   in   1      1-cycle pulse from the drop sensor
//  eject5        out  1      $5 hopper motor
//  eject2        out  1      $2 hopper motor
//  eject1        out  1      $1 hopper motor
//  busy          out  1      high in every state except IDLE
//  done          out  1      1-cycle pulse when payout ends
//  short_pay     out  1      set with done if remaining!=0; held until next start
//  remaining     out  8      amount still owed
//  cnt5          out  CNT_W  coins currently in the $5 hopper
//  cnt2          out  CNT_W  coins currently in the $2 hopper
//  cnt1          out  CNT_W  coins currently in the $1 hopper
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0, including the counts.
//   Reset takes effect immediately: motors drop the same instant; a payout in progress is abandoned with no done.
//  FSM states: IDLE, SELECT, EJECT, WAIT_SENSE, GAP, DONE.
//  IDLE:
//   start=1 -> remaining<=change_amt, short_pay<=0, go to SELECT.
//   refill=1 (with start=0) -> load all three counts.
//   start and refill in the same cycle -> start wins; refill is dropped.
//  SELECT (1 cycle): greedy choice of the largest d in {5,2,1} with d<=remaining and cnt_d>0.
//   remaining==0 -> DONE.
//   No coin qualifies -> DONE with short_pay=1.
//   Greedy is not backtracked: remaining 6 with cnt5>0 and cnt1==0 ends short by 1. This is by design.
//  EJECT: eject_d high for exactly PULSE_CYCLES cycles; only one eject line is ever high.
//   coin_sensed during EJECT is latched; the pulse still finishes, then go to GAP.
//   No sense yet -> WAIT_SENSE.
//  WAIT_SENSE: coin_sensed -> go to GAP. No pulse within TIMEOUT cycles = jam:
//   cnt_d<=0 (hopper marked empty); remaining unchanged; go to GAP.
//  Sensed coin: cnt_d<=cnt_d-1 and remaining<=remaining-d, both in the sensing cycle.
//   No underflow is possible because SELECT guarantees d<=remaining and cnt_d>0.
//  GAP: GAP_CYCLES cycles, then SELECT.
//  DONE: done=1 for one cycle, busy=0 on the following cycle, then IDLE.
//  Ignored inputs: coin_sensed in IDLE, SELECT, GAP or DONE. start and refill while busy.
//  Latency: start at edge N -> SELECT at N+1 -> eject rises at N+2.
//   change_amt=0 -> done at N+2.
// TESTING
//  T1: refill 3/3/3, start amt=8, sense each coin -> eject order 5,2,1; done, short_pay=0; counts 2/2/2.
//  T2: refill 0/3/3, start amt=6 -> three $2 coins; remaining 0; cnt2=0, cnt1=3.
//  T3: refill 0/0/1, start amt=3 -> one $1 coin; done, short_pay=1, remaining=2.
//  T4: refill 1/3/0, start amt=5, never sense the $5 -> after TIMEOUT cnt5=0; two $2 coins paid; short_pay=1, remaining=1.
//  T5: amt=0 -> done 2 cycles after start, no eject.
//   start/refill pulsed mid-payout -> no effect.
//  T6: rst_n low during EJECT -> all ejects 0 at once; busy=0, counts 0; next start works normally after refill.

Source files
------------

// File: rtl/change_dispense_sequencer.sv
// Change payout sequencer for three coin hoppers ($5, $2, $1).
// Greedy coin choice, one coin at a time, each drop confirmed by the sensor.
module change_dispense_sequencer #(
    parameter int PULSE_CYCLES = 4,
    parameter int TIMEOUT      = 16,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       change_amt,
    input  logic             refill,
    input  logic [CNT_W-1:0] refill_cnt5,
    input  logic [CNT_W-1:0] refill_cnt2,
    input  logic [CNT_W-1:0] refill_cnt1,
    input  logic             coin_sensed,
    output logic             eject5,
    output logic             eject2,
    output logic             eject1,
    output logic             busy,
    output logic             done,
    output logic             short_pay,
    output logic [7:0]       remaining,
    output logic [CNT_W-1:0] cnt5,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt1
);

    localparam int TW = 16;
    localparam logic [TW-1:0] P_LAST = TW'(PULSE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] G_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ej_q, ej_d;
    logic             sensed_q, sensed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             short_q, short_d;
    logic [7:0]       rem_q, rem_d;
    logic [CNT_W-1:0] c5_q, c5_d;
    logic [CNT_W-1:0] c2_q, c2_d;
    logic [CNT_W-1:0] c1_q, c1_d;

    logic       fit5, fit2, fit1;
    logic       sense_ok;
    logic [7:0] val;

    assign fit5 = (rem_q >= 8'd5) && (c5_q != '0);
    assign fit2 = (rem_q >= 8'd2) && (c2_q != '0);
    assign fit1 = (rem_q >= 8'd1) && (c1_q != '0);
    assign val  = sel_q[2] ? 8'd5 : (sel_q[1] ? 8'd2 : 8'd1);

    // Only the first sense of a coin counts; later pulses are stray.
    assign sense_ok = coin_sensed &&
                      ((state_q == S_EJECT && !sensed_q) ||
                       state_q == S_WAIT);

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        sel_d    = sel_q;
        ej_d     = ej_q;
        sensed_d = sensed_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        short_d  = short_q;
        rem_d    = rem_q;
        c5_d     = c5_q;
        c2_d     = c2_q;
        c1_d     = c1_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = change_amt;
                    short_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SELECT;
                end else if (refill) begin
                    c5_d = refill_cnt5;
                    c2_d = refill_cnt2;
                    c1_d = refill_cnt1;
                end
            end
            S_SELECT: begin
                if (rem_q == 8'd0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else if (fit5 || fit2 || fit1) begin
                    if (fit5)      sel_d = 3'b100;
                    else if (fit2) sel_d = 3'b010;
                    else           sel_d = 3'b001;
                    ej_d     = sel_d;
                    tmr_d    = '0;
                    sensed_d = 1'b0;
                    state_d  = S_EJECT;
                end else begin
                    done_d  = 1'b1;
                    short_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_EJECT: begin
                if (sense_ok) sensed_d = 1'b1;
                if (tmr_q == P_LAST) begin
                    ej_d    = 3'b000;
                    tmr_d   = '0;
                    state_d = (sensed_q || sense_ok) ? S_GAP : S_WAIT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (sense_ok) begin
                    tmr_d   = '0;
                    state_d = S_GAP;
                end else if (tmr_q == T_LAST) begin
                    // Jam: treat this hopper as empty from now on.
                    if (sel_q[2]) c5_d = '0;
                    if (sel_q[1]) c2_d = '0;
                    if (sel_q[0]) c1_d = '0;
                    tmr_d   = '0;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_GAP: begin
                if (tmr_q == G_LAST) begin
                    tmr_d   = '0;
                    state_d = S_SELECT;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sense_ok) begin
            rem_d = rem_q - val;
            if (sel_q[2]) c5_d = c5_q - CNT_W'(1);
            if (sel_q[1]) c2_d = c2_q - CNT_W'(1);
            if (sel_q[0]) c1_d = c1_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            sel_q    <= 3'b000;
            ej_q     <= 3'b000;
            sensed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            short_q  <= 1'b0;
            rem_q    <= 8'd0;
            c5_q     <= '0;
            c2_q     <= '0;
            c1_q     <= '0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            sel_q    <= sel_d;
            ej_q     <= ej_d;
            sensed_q <= sensed_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            short_q  <= short_d;
            rem_q    <= rem_d;
            c5_q     <= c5_d;
            c2_q     <= c2_d;
            c1_q     <= c1_d;
        end
    end

    assign eject5    = ej_q[2];
    assign eject2    = ej_q[1];
    assign eject1    = ej_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign short_pay = short_q;
    assign remaining = rem_q;
    assign cnt5      = c5_q;
    assign cnt2      = c2_q;
    assign cnt1      = c1_q;

endmodule

// File: tb/tb_change_dispense_sequencer.sv
// Bench for change_dispense_sequencer: directed payouts plus random
// payouts checked against a greedy arithmetic model of the hoppers.
module tb_change_dispense_sequencer;

    localparam int P = 4;
    localparam int T = 16;
    localparam int G = 2;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [7:0]   change_amt;
    logic         refill;
    logic [W-1:0] refill_cnt5, refill_cnt2, refill_cnt1;
    logic         coin_sensed;
    logic         eject5, eject2, eject1;
    logic         busy, done, short_pay;
    logic [7:0]   remaining;
    logic [W-1:0] cnt5, cnt2, cnt1;

    always #5 clk = ~clk;

    change_dispense_sequencer #(
        .PULSE_CYCLES(P),
        .TIMEOUT(T),
        .GAP_CYCLES(G),
        .CNT_W(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .change_amt(change_amt),
        .refill(refill),
        .refill_cnt5(refill_cnt5),
        .refill_cnt2(refill_cnt2),
        .refill_cnt1(refill_cnt1),
        .coin_sensed(coin_sensed),
        .eject5(eject5),
        .eject2(eject2),
        .eject1(eject1),
        .busy(busy),
        .done(done),
        .short_pay(short_pay),
        .remaining(remaining),
        .cnt5(cnt5),
        .cnt2(cnt2),
        .cnt1(cnt1)
    );

    int checks = 0;
    int failures = 0;
    int m5, m2, m1, mrem;
    bit mshort;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int rem, input int c5,
                                input int c2, input int c1);
        if (rem >= 5 && c5 > 0) return 5;
        if (rem >= 2 && c2 > 0) return 2;
        if (rem >= 1 && c1 > 0) return 1;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_cnt5"}, cnt5, m5);
        check({tag, "_cnt2"}, cnt2, m2);
        check({tag, "_cnt1"}, cnt1, m1);
    endtask

    task automatic do_refill(input int a, input int b, input int c);
        refill = 1'b1;
        refill_cnt5 = W'(a);
        refill_cnt2 = W'(b);
        refill_cnt1 = W'(c);
        step();
        refill = 1'b0;
        m5 = a;
        m2 = b;
        m1 = c;
        check_counts("refill");
    endtask

    // mode 0: sense every coin; 1: never sense $5; 2: random jams
    task automatic run_payout(input int amt, input int mode, input bit noise);
        int c, cur, width, e_start, s_at, d, exp_d;
        bit first, finished, sense;
        logic [2:0] ej;
        start = 1'b1;
        change_amt = 8'(amt);
        step();
        start = 1'b0;
        refill = 1'b0;
        mrem = amt;
        mshort = 1'b0;
        check("busy_after_start", busy, 1);
        c = 0;
        cur = 0;
        width = 0;
        e_start = -1000;
        s_at = -1;
        first = 1'b1;
        finished = 1'b0;
        while (!finished && c < 2000) begin
            step();
            c++;
            coin_sensed = 1'b0;
            start = 1'b0;
            refill = 1'b0;
            ej = {eject5, eject2, eject1};
            check("eject_onehot", ($countones(ej) <= 1), 1);
            if (ej != 3'b000) begin
                d = ej[2] ? 5 : (ej[1] ? 2 : 1);
                if (cur == 0) begin
                    exp_d = pick(mrem, m5, m2, m1);
                    check("coin_denom", d, exp_d);
                    check("rem_at_eject", remaining, mrem);
                    if (first) check("first_eject_latency", c, 1);
                    first = 1'b0;
                    cur = d;
                    width = 0;
                    e_start = c;
                    if (mode == 0) sense = 1'b1;
                    else if (mode == 1) sense = (d != 5);
                    else sense = ($urandom_range(0, 4) != 0);
                    if (sense) begin
                        case ($urandom_range(0, 3))
                            0: s_at = 0;
                            1: s_at = P + T - 1;
                            default: s_at = $urandom_range(0, P + T - 1);
                        endcase
                        mrem -= d;
                        if (d == 5) m5--;
                        else if (d == 2) m2--;
                        else m1--;
                    end else begin
                        s_at = ($urandom_range(0, 1) == 1) ?
                               P + T + $urandom_range(0, 2) : -1;
                        if (d == 5) m5 = 0;
                        else if (d == 2) m2 = 0;
                        else m1 = 0;
                    end
                end
                width++;
            end else if (cur != 0) begin
                check("pulse_width", width, P);
                cur = 0;
            end
            if (s_at >= 0 && c == e_start + s_at) begin
                coin_sensed = 1'b1;
                s_at = -1;
            end
            if (done) begin
                finished = 1'b1;
                coin_sensed = 1'b0;
                mshort = (mrem != 0);
                check("done_no_eject", ej, 0);
                check("done_busy", busy, 1);
                check("done_remaining", remaining, mrem);
                check("done_short", short_pay, mshort);
                check("done_next_pick", pick(mrem, m5, m2, m1), 0);
                check_counts("done");
                if (amt == 0) check("zero_amt_done_latency", c, 1);
            end else if (noise && $urandom_range(0, 5) == 0) begin
                start = 1'b1;
                change_amt = 8'($urandom_range(0, 255));
                refill = 1'b1;
                refill_cnt5 = W'($urandom_range(0, 15));
                refill_cnt2 = W'($urandom_range(0, 15));
                refill_cnt1 = W'($urandom_range(0, 15));
            end
        end
        if (!finished) check("payout_timeout", 0, 1);
        start = 1'b0;
        refill = 1'b0;
        coin_sensed = 1'b0;
        step();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("short_held", short_pay, mshort);
        check_counts("idle");
    endtask

    initial begin
        bit seen;
        rst_n = 1'b0;
        start = 1'b0;
        change_amt = 8'd0;
        refill = 1'b0;
        refill_cnt5 = '0;
        refill_cnt2 = '0;
        refill_cnt1 = '0;
        coin_sensed = 1'b0;
        m5 = 0;
        m2 = 0;
        m1 = 0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_short", short_pay, 0);
        check("rst_ejects", {eject5, eject2, eject1}, 0);
        check("rst_remaining", remaining, 0);
        check_counts("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        do_refill(3, 3, 3);
        run_payout(8, 0, 1'b0);
        do_refill(0, 3, 3);
        run_payout(6, 0, 1'b0);
        do_refill(0, 0, 1);
        run_payout(3, 0, 1'b0);
        do_refill(1, 3, 0);
        run_payout(5, 1, 1'b0);
        run_payout(0, 0, 1'b1);
        do_refill(2, 2, 2);
        run_payout(9, 0, 1'b1);

        // greedy without backtracking leaves 6 short by 1
        do_refill(2, 0, 0);
        run_payout(6, 0, 1'b0);

        // start and refill together: start wins, refill dropped
        do_refill(5, 5, 5);
        refill = 1'b1;
        refill_cnt5 = W'(1);
        refill_cnt2 = W'(1);
        refill_cnt1 = W'(1);
        run_payout(0, 0, 1'b0);

        // asynchronous reset in the middle of a pulse
        do_refill(2, 2, 2);
        start = 1'b1;
        change_amt = 8'd9;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = eject5;
        end
        check("t6_eject_seen", seen, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_ejects_off", {eject5, eject2, eject1}, 0);
        check("t6_busy", busy, 0);
        check("t6_remaining", remaining, 0);
        m5 = 0;
        m2 = 0;
        m1 = 0;
        check_counts("t6");
        step();
        check("t6_no_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        do_refill(1, 1, 1);
        run_payout(8, 0, 1'b0);

        for (int n = 0; n < 30; n++) begin
            do_refill($urandom_range(0, 15), $urandom_range(0, 15),
                      $urandom_range(0, 15));
            run_payout($urandom_range(0, 40), 2, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
